// File: rtl/adder_tree_accumulator.sv
// Sums up to ACC_COUNT adder-tree results into one frame total, output held until taken.
// Latency: out_valid rises on the edge that accepts the final beat of a frame.
// Backpressure: in_ready drops for the whole HOLD phase (at least one cycle per frame).
module adder_tree_accumulator #(
  parameter int ADDER_WIDTH  = 32,
  parameter int TREE_LEVELS  = 3,
  parameter int ACC_COUNT    = 16,
  localparam int IN_WIDTH    = ADDER_WIDTH + TREE_LEVELS,
  localparam int ACC_WIDTH   = IN_WIDTH + $clog2(ACC_COUNT),
  localparam int CNT_WIDTH   = $clog2(ACC_COUNT + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_sum,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_total,
  output logic [CNT_WIDTH-1:0] out_count
);

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(ACC_COUNT - 1);

  logic [0:0]           state;
  logic [ACC_WIDTH-1:0] acc;
  logic [CNT_WIDTH-1:0] cnt;

  logic                 accept;
  logic                 final_beat;
  logic [ACC_WIDTH-1:0] acc_next;
  logic [CNT_WIDTH-1:0] cnt_next;

  // in_ready comes straight off the state register: no input-to-output path.
  assign in_ready   = (state == ACCUM);
  assign accept     = in_valid && in_ready;
  assign final_beat = (cnt == LAST_CNT) || in_last;
  assign acc_next   = acc + ACC_WIDTH'(in_sum);
  assign cnt_next   = cnt + CNT_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_total <= '0;
      out_count <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            if (final_beat) begin
              out_total <= acc_next;
              out_count <= cnt_next;
              out_valid <= 1'b1;
              acc       <= '0;
              cnt       <= '0;
              state     <= HOLD;
            end else begin
              acc <= acc_next;
              cnt <= cnt_next;
            end
          end
        end
        HOLD: begin
          // Output registers are only rewritten in ACCUM, so they stay frozen here.
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
